// File: rtl/voice_alloc_pkg.sv
// Shared types and widths for the voice allocator.
//   VOICE_IDX_W : width of the voice index presented to downstream stages
//   NOTE_W      : MIDI note number width
//   VEL_W       : MIDI velocity width
//   state_t     : allocator FSM state encoding
//   midi_event_t: event captured on accept (velocity-0 note-on already folded to key-up)
package voice_alloc_pkg;

    localparam int unsigned VOICE_IDX_W = 8;
    localparam int unsigned NOTE_W      = 7;
    localparam int unsigned VEL_W       = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    typedef struct packed {
        logic              key_down;
        logic [NOTE_W-1:0] note;
    } midi_event_t;

endpackage

// File: rtl/voice_table.sv
// Per-voice table: active bit + note number, one async read port, one write port.
//   i_clk, i_reset_n       : clock, synchronous active-low reset (clears active bits)
//   rd_idx                 : read address
//   rd_active_c, rd_note_c : combinational read data
//   we, wr_idx             : write strobe and address
//   wr_active, wr_note     : write data
module voice_table
    import voice_alloc_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 16,
    parameter int unsigned IDX_W      = 4
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_active_c,
    output logic [NOTE_W-1:0] rd_note_c,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic              wr_active,
    input  logic [NOTE_W-1:0] wr_note
);

    logic [NUM_VOICES-1:0] active_q;
    logic [NOTE_W-1:0]     note_q [NUM_VOICES];

    // Active bits must clear on reset; note storage is don't-care while inactive.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            active_q <= '0;
        end else if (we) begin
            active_q[wr_idx] <= wr_active;
        end
    end

    always_ff @(posedge i_clk) begin
        if (we) begin
            note_q[wr_idx] <= wr_note;
        end
    end

    assign rd_active_c = active_q[rd_idx];
    assign rd_note_c   = note_q[rd_idx];

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: accepts MIDI note events, scans the voice table
// one voice per clock, picks a target voice (retrigger > free > steal) and
// issues keystate / pitch-table update strobes, then enforces a minimum gap.
//   i_clk, i_reset_n                    : clock, synchronous active-low reset
//   i_midi_valid / o_midi_ready         : event handshake
//   i_midi_note_on, i_midi_note,
//   i_midi_velocity                     : event payload
//   o_SPI_flag, o_SPI_note_status,
//   o_SPI_voice_index                   : keystate update to envelope stage
//   o_note_we, o_note_value             : pitch-table write to oscillator stage
module voice_alloc
    import voice_alloc_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 16,
    parameter int unsigned FLAG_GAP   = 8
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_midi_valid,
    output logic       o_midi_ready,
    input  logic       i_midi_note_on,
    input  logic [6:0] i_midi_note,
    input  logic [6:0] i_midi_velocity,
    output logic       o_SPI_flag,
    output logic       o_SPI_note_status,
    output logic [7:0] o_SPI_voice_index,
    output logic       o_note_we,
    output logic [6:0] o_note_value
);

    localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int unsigned GAP_W = (FLAG_GAP > 1) ? $clog2(FLAG_GAP) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((FLAG_GAP > 0) ? FLAG_GAP - 1 : 0);

    state_t                 state_q, state_d;
    midi_event_t            ev_q, ev_d;
    logic [IDX_W-1:0]       scan_idx_q, scan_idx_d;
    logic                   free_found_q, free_found_d;
    logic [IDX_W-1:0]       free_idx_q, free_idx_d;
    logic                   match_found_q, match_found_d;
    logic [IDX_W-1:0]       match_idx_q, match_idx_d;
    logic [IDX_W-1:0]       steal_q, steal_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic                   ready_q, ready_d;
    logic                   flag_q, flag_d;
    logic                   status_q, status_d;
    logic [VOICE_IDX_W-1:0] vidx_q, vidx_d;
    logic                   we_q, we_d;
    logic [NOTE_W-1:0]      nval_q, nval_d;

    logic                   rd_active_c;
    logic [NOTE_W-1:0]      rd_note_c;
    logic                   tbl_we_c;

    // Scan results including the entry being read this cycle.
    logic                   nf_found_c, nm_found_c;
    logic [IDX_W-1:0]       nf_idx_c, nm_idx_c, target_c;

    // Table is updated in ISSUE using the decision registered on the last scan cycle.
    assign tbl_we_c = (state_q == ST_ISSUE);

    voice_table #(
        .NUM_VOICES (NUM_VOICES),
        .IDX_W      (IDX_W)
    ) u_voice_table (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .rd_idx      (scan_idx_q),
        .rd_active_c (rd_active_c),
        .rd_note_c   (rd_note_c),
        .we          (tbl_we_c),
        .wr_idx      (vidx_q[IDX_W-1:0]),
        .wr_active   (status_q),
        .wr_note     (ev_q.note)
    );

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q       <= ST_IDLE;
            ev_q          <= '0;
            scan_idx_q    <= '0;
            free_found_q  <= 1'b0;
            free_idx_q    <= '0;
            match_found_q <= 1'b0;
            match_idx_q   <= '0;
            steal_q       <= '0;
            gap_cnt_q     <= '0;
            ready_q       <= 1'b1;
            flag_q        <= 1'b0;
            status_q      <= 1'b0;
            vidx_q        <= '0;
            we_q          <= 1'b0;
            nval_q        <= '0;
        end else begin
            state_q       <= state_d;
            ev_q          <= ev_d;
            scan_idx_q    <= scan_idx_d;
            free_found_q  <= free_found_d;
            free_idx_q    <= free_idx_d;
            match_found_q <= match_found_d;
            match_idx_q   <= match_idx_d;
            steal_q       <= steal_d;
            gap_cnt_q     <= gap_cnt_d;
            ready_q       <= ready_d;
            flag_q        <= flag_d;
            status_q      <= status_d;
            vidx_q        <= vidx_d;
            we_q          <= we_d;
            nval_q        <= nval_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        ev_d          = ev_q;
        scan_idx_d    = scan_idx_q;
        free_found_d  = free_found_q;
        free_idx_d    = free_idx_q;
        match_found_d = match_found_q;
        match_idx_d   = match_idx_q;
        steal_d       = steal_q;
        gap_cnt_d     = gap_cnt_q;
        flag_d        = 1'b0;
        we_d          = 1'b0;
        status_d      = status_q;
        vidx_d        = vidx_q;
        nval_d        = nval_q;
        target_c      = steal_q;

        // Lowest index wins: keep an earlier hit, otherwise take the current voice.
        nf_found_c = free_found_q | ~rd_active_c;
        nf_idx_c   = free_found_q ? free_idx_q : scan_idx_q;
        nm_found_c = match_found_q | (rd_active_c && (rd_note_c == ev_q.note));
        nm_idx_c   = match_found_q ? match_idx_q : scan_idx_q;

        case (state_q)
            ST_IDLE: begin
                if (i_midi_valid) begin
                    ev_d.key_down = i_midi_note_on && (i_midi_velocity != '0);
                    ev_d.note     = i_midi_note;
                    scan_idx_d    = '0;
                    free_found_d  = 1'b0;
                    match_found_d = 1'b0;
                    state_d       = ST_SCAN;
                end
            end
            ST_SCAN: begin
                free_found_d  = nf_found_c;
                free_idx_d    = nf_idx_c;
                match_found_d = nm_found_c;
                match_idx_d   = nm_idx_c;
                scan_idx_d    = scan_idx_q + 1'b1;
                if (scan_idx_q == LAST_IDX) begin
                    scan_idx_d = '0;
                    if (ev_q.key_down) begin
                        if (nm_found_c) begin
                            target_c = nm_idx_c;
                        end else if (nf_found_c) begin
                            target_c = nf_idx_c;
                        end else begin
                            target_c = steal_q;
                            steal_d  = (steal_q == LAST_IDX) ? '0 : steal_q + 1'b1;
                        end
                        flag_d   = 1'b1;
                        status_d = 1'b1;
                        we_d     = 1'b1;
                        nval_d   = ev_q.note;
                        vidx_d   = VOICE_IDX_W'(target_c);
                        state_d  = ST_ISSUE;
                    end else if (nm_found_c) begin
                        flag_d   = 1'b1;
                        status_d = 1'b0;
                        vidx_d   = VOICE_IDX_W'(nm_idx_c);
                        state_d  = ST_ISSUE;
                    end else begin
                        // Release of a note that is not sounding: nothing to do.
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ISSUE: begin
                gap_cnt_d = '0;
                state_d   = (FLAG_GAP == 0) ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    assign o_midi_ready      = ready_q;
    assign o_SPI_flag        = flag_q;
    assign o_SPI_note_status = status_q;
    assign o_SPI_voice_index = vidx_q;
    assign o_note_we         = we_q;
    assign o_note_value      = nval_q;

endmodule

// File: tb/tb_voice_alloc.sv
// Directed, table-driven bench for voice_alloc (NUM_VOICES=16, FLAG_GAP=8).
module tb_voice_alloc;

    localparam int NV = 16;
    localparam int FG = 8;

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_midi_valid = 1'b0;
    logic       o_midi_ready;
    logic       i_midi_note_on = 1'b0;
    logic [6:0] i_midi_note = '0;
    logic [6:0] i_midi_velocity = '0;
    logic       o_SPI_flag;
    logic       o_SPI_note_status;
    logic [7:0] o_SPI_voice_index;
    logic       o_note_we;
    logic [6:0] o_note_value;

    voice_alloc #(.NUM_VOICES(NV), .FLAG_GAP(FG)) dut (
        .i_clk             (i_clk),
        .i_reset_n         (i_reset_n),
        .i_midi_valid      (i_midi_valid),
        .o_midi_ready      (o_midi_ready),
        .i_midi_note_on    (i_midi_note_on),
        .i_midi_note       (i_midi_note),
        .i_midi_velocity   (i_midi_velocity),
        .o_SPI_flag        (o_SPI_flag),
        .o_SPI_note_status (o_SPI_note_status),
        .o_SPI_voice_index (o_SPI_voice_index),
        .o_note_we         (o_note_we),
        .o_note_value      (o_note_value)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_flag_cyc = -1000;

    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        bit on;
        int note;
        int vel;
        bit exp_flag;
        int exp_voice;
        int exp_status;
        int exp_we;
        int exp_note;
    } vec_t;

    vec_t tbl1[$];
    vec_t tbl2[$];

    function automatic vec_t mk(bit on, int note, int vel, bit ef, int voice, int st, int we, int nv);
        vec_t v;
        v.on = on; v.note = note; v.vel = vel; v.exp_flag = ef;
        v.exp_voice = voice; v.exp_status = st; v.exp_we = we; v.exp_note = nv;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with o_midi_ready high (or a logged timeout).
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (o_midi_ready !== 1'b1 && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        if (o_midi_ready !== 1'b1) check({name, " ready timeout"}, o_midi_ready, 1);
    endtask

    // Offer one event, follow it to its strobe (or to the return of ready) and check it.
    task automatic run_event(input string name, input vec_t v);
        int  n;
        bit  seen;
        bit  done;
        wait_ready(name);
        i_midi_valid    = 1'b1;
        i_midi_note_on  = v.on;
        i_midi_note     = 7'(v.note);
        i_midi_velocity = 7'(v.vel);
        @(posedge i_clk);
        #1 i_midi_valid = 1'b0;
        n = 0; seen = 0; done = 0;
        while (!done) begin
            @(negedge i_clk);
            n++;
            if (n == 1) check({name, " busy"}, o_midi_ready, 0);
            if (o_SPI_flag === 1'b1) begin
                seen = 1; done = 1;
            end else if (!v.exp_flag && o_midi_ready === 1'b1) begin
                done = 1;
            end else if (n >= 40) begin
                done = 1;
            end
        end
        check({name, " flag"}, seen, v.exp_flag);
        check({name, " latency"}, n, NV + 1);
        if (seen) begin
            check({name, " voice"}, o_SPI_voice_index, v.exp_voice);
            check({name, " status"}, o_SPI_note_status, v.exp_status);
            check({name, " we"}, o_note_we, v.exp_we);
            check({name, " note"}, o_note_value, v.exp_note);
            check({name, " spacing"}, (cyc - last_flag_cyc) >= FG + 1, 1);
            last_flag_cyc = cyc;
            @(negedge i_clk);
            check({name, " flag one-cycle"}, o_SPI_flag, 0);
            check({name, " we one-cycle"}, o_note_we, 0);
            check({name, " status hold"}, o_SPI_note_status, v.exp_status);
        end
    endtask

    initial begin
        int nflags;

        // Voice 0 ends holding note 30 and voice 1 note 64, so a later reset must clear them.
        tbl1.push_back(mk(1, 60, 100, 1, 0, 1, 1, 60));
        tbl1.push_back(mk(1, 64, 100, 1, 1, 1, 1, 60 + 4));
        tbl1.push_back(mk(0, 60,   0, 1, 0, 0, 0, 64));  // note value holds from last write
        tbl1.push_back(mk(1, 62,  90, 1, 0, 1, 1, 62));  // lowest free voice
        tbl1.push_back(mk(1, 62,   0, 1, 0, 0, 0, 62));  // velocity 0 acts as release
        tbl1.push_back(mk(0, 99,  40, 0, 0, 0, 0, 0));   // release of unplayed note
        tbl1.push_back(mk(1, 64,  50, 1, 1, 1, 1, 64));  // retrigger beats lower free voice
        tbl1.push_back(mk(1, 30,  10, 1, 0, 1, 1, 30));

        tbl2.push_back(mk(1, 60, 100, 1, 0, 1, 1, 60));  // table cleared by reset
        tbl2.push_back(mk(0, 60,  64, 1, 0, 0, 0, 60));
        for (int k = 0; k < NV; k++) tbl2.push_back(mk(1, 40 + k, 100, 1, k, 1, 1, 40 + k));
        // All busy: steal pointer hands out voice 0 then 1. A repeated 70 would
        // retrigger voice 0 by note match, so the second steal uses 71.
        tbl2.push_back(mk(1, 70, 100, 1, 0, 1, 1, 70));
        tbl2.push_back(mk(1, 71, 100, 1, 1, 1, 1, 71));
        tbl2.push_back(mk(1, 70, 100, 1, 0, 1, 1, 70));

        // Reset values
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        @(negedge i_clk);
        check("rst ready", o_midi_ready, 1);
        check("rst flag", o_SPI_flag, 0);
        check("rst we", o_note_we, 0);
        check("rst status", o_SPI_note_status, 0);
        check("rst voice", o_SPI_voice_index, 0);
        check("rst note", o_note_value, 0);

        for (int i = 0; i < tbl1.size(); i++) run_event($sformatf("t1_%0d", i), tbl1[i]);

        // Reset in the middle of a scan aborts the event.
        wait_ready("abort");
        i_midi_valid    = 1'b1;
        i_midi_note_on  = 1'b1;
        i_midi_note     = 7'd61;
        i_midi_velocity = 7'd80;
        @(posedge i_clk);
        #1 i_midi_valid = 1'b0;
        repeat (5) @(negedge i_clk);
        i_reset_n = 1'b0;
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;
        nflags = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge i_clk);
            if (k == 0) begin
                check("abort ready", o_midi_ready, 1);
                check("abort voice", o_SPI_voice_index, 0);
                check("abort note", o_note_value, 0);
            end
            if (o_SPI_flag === 1'b1) nflags++;
        end
        check("abort no flag", nflags, 0);

        for (int i = 0; i < tbl2.size(); i++) run_event($sformatf("t2_%0d", i), tbl2[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
